// File: rtl/aww_types_pkg.sv
// rtl/aww_types_pkg.sv - Arbiter FSM state encoding.
package aww_types_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - Shared datapath types: machine word and RAM status.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Requester and RAM signals seen by the memory arbiter.
interface mem_arbiter_if;

  logic                     iREN;
  cpu_types_pkg::word_t     iaddr;
  logic                     iwait;
  cpu_types_pkg::word_t     iload;

  logic                     dREN;
  logic                     dWEN;
  cpu_types_pkg::word_t     daddr;
  cpu_types_pkg::word_t     dstore;
  logic                     dwait;
  cpu_types_pkg::word_t     dload;

  logic                     ramREN;
  logic                     ramWEN;
  cpu_types_pkg::word_t     ramaddr;
  cpu_types_pkg::word_t     ramstore;
  cpu_types_pkg::word_t     ramload;
  cpu_types_pkg::ramstate_t ramstate;

  logic                     err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Single-port RAM arbiter, data priority with bounded instruction starvation.
module mem_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);

  localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                err_q, err_d;

  logic d_req;
  logic access;

  assign d_req  = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == ACCESS);

  assign bus.iwait = bus.iREN & ~((state_q == IGRANT) & access);
  assign bus.dwait = d_req & ~((state_q == DGRANT) & access);
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  assign bus.err   = err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    err_d        = err_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    unique case (state_q)
      IDLE: begin
        // Data wins unless the instruction side has already been passed over LIMIT times.
        if (d_req && (!bus.iREN || STARVE_LIMIT == 0 || streak_q < LIMIT)) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (access) begin
          state_d  = IDLE;
          streak_d = '0;
        end
      end
      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (access) begin
          state_d = IDLE;
          if (!bus.iREN) begin
            streak_d = '0;
          end else if (streak_q < LIMIT) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && bus.ramstate == ERROR) begin
      err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Directed and randomized checks of mem_arbiter against a transaction model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 2;

  logic CLK = 1'b0;
  logic nRST;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: who owns the RAM (0 none, 1 instruction, 2 data), data-win streak, sticky error.
  int m_own    = 0;
  int m_streak = 0;
  bit m_err    = 1'b0;

  bit          i_done, d_done;
  logic        obs_ren, obs_wen, obs_iwait, obs_dwait, obs_err;
  logic [31:0] obs_addr, obs_store, obs_iload;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Inputs are set after a rising edge; outputs are checked on the falling edge.
  task automatic step();
    logic        e_ren, e_wen, e_iwait, e_dwait;
    logic [31:0] e_addr, e_store;
    bit          acc, dreq;
    @(negedge CLK);
    #1;
    if (!nRST) begin
      m_own = 0; m_streak = 0; m_err = 1'b0;
    end
    acc  = (bus.ramstate == ACCESS);
    dreq = bus.dREN | bus.dWEN;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    if (m_own == 1) begin
      e_ren = 1'b1; e_addr = bus.iaddr;
    end else if (m_own == 2) begin
      e_wen = bus.dWEN; e_ren = bus.dREN & ~bus.dWEN;
      e_addr = bus.daddr; e_store = bus.dstore;
    end
    e_iwait = bus.iREN & ~(m_own == 1 && acc);
    e_dwait = dreq & ~(m_own == 2 && acc);

    chk("ramREN", {31'b0, bus.ramREN}, {31'b0, e_ren});
    chk("ramWEN", {31'b0, bus.ramWEN}, {31'b0, e_wen});
    chk("ramaddr", bus.ramaddr, e_addr);
    chk("ramstore", bus.ramstore, e_store);
    chk("iwait", {31'b0, bus.iwait}, {31'b0, e_iwait});
    chk("dwait", {31'b0, bus.dwait}, {31'b0, e_dwait});
    chk("err", {31'b0, bus.err}, {31'b0, m_err});
    if (bus.iREN && !e_iwait) chk("iload", bus.iload, bus.ramload);
    if (dreq && !e_dwait)     chk("dload", bus.dload, bus.ramload);

    obs_ren = bus.ramREN;  obs_wen = bus.ramWEN;  obs_addr = bus.ramaddr;
    obs_store = bus.ramstore; obs_iwait = bus.iwait; obs_dwait = bus.dwait;
    obs_err = bus.err; obs_iload = bus.iload;
    i_done = bus.iREN && !e_iwait;
    d_done = dreq && !e_dwait;

    if (nRST) begin
      if (m_own != 0 && bus.ramstate == ERROR) m_err = 1'b1;
      case (m_own)
        0: if (dreq && (!bus.iREN || LIM == 0 || m_streak < LIM)) m_own = 2;
           else if (bus.iREN) m_own = 1;
        1: if (!bus.iREN) m_own = 0;
           else if (acc) begin m_own = 0; m_streak = 0; end
        2: if (!dreq) m_own = 0;
           else if (acc) begin
             m_own = 0;
             m_streak = bus.iREN ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
           end
        default: m_own = 0;
      endcase
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [23:0] order;
    int          r;

    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = 32'hDEADBEEF; bus.ramstate = ACCESS;
    step();
    chk("rst_ramREN", {31'b0, obs_ren}, 32'd0);
    chk("rst_iwait", {31'b0, obs_iwait}, 32'd1);
    chk("rst_err", {31'b0, obs_err}, 32'd0);
    step();
    nRST = 1'b1;

    // Instruction fetch with one-cycle RAM latency.
    step();
    chk("ifetch_wait_c1", {31'b0, obs_iwait}, 32'd1);
    step();
    chk("ifetch_wait_c2", {31'b0, obs_iwait}, 32'd0);
    chk("ifetch_load", obs_iload, 32'hDEADBEEF);
    chk("ifetch_addr", obs_addr, 32'h40);

    // Starvation bound: two data grants, then the waiting fetch.
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h55;
    order = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (obs_ren || obs_wen) order = {order[15:0], (obs_wen ? 8'h44 : 8'h49)};
    end
    chk("grant_order", {8'h0, order}, {8'h0, 24'h444449});

    // Write wins over read when both are asserted.
    bus.iREN = 1'b0; bus.dREN = 1'b1; bus.dWEN = 1'b1;
    bus.daddr = 32'h80; bus.dstore = 32'h1234; bus.ramstate = BUSY;
    step();
    step();
    chk("wr_ramWEN", {31'b0, obs_wen}, 32'd1);
    chk("wr_ramREN", {31'b0, obs_ren}, 32'd0);
    chk("wr_ramstore", obs_store, 32'h1234);
    chk("wr_ramaddr", obs_addr, 32'h80);

    // Abort: request drops while still granted.
    bus.dREN = 1'b0; bus.dWEN = 1'b0;
    step();
    chk("abort_dwait", {31'b0, obs_dwait}, 32'd0);
    step();
    chk("abort_idle_addr", obs_addr, 32'h0);

    // RAM error during an instruction grant is sticky.
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.ramstate = ERROR;
    step();
    step();
    step();
    chk("err_set", {31'b0, obs_err}, 32'd1);
    chk("err_iwait", {31'b0, obs_iwait}, 32'd1);
    bus.ramstate = ACCESS;
    step();
    bus.iREN = 1'b0;
    step();
    step();
    chk("err_held", {31'b0, obs_err}, 32'd1);

    // Asynchronous reset in the middle of a data write.
    bus.dWEN = 1'b1; bus.ramstate = BUSY;
    step();
    step();
    chk("pre_rst_wen", {31'b0, obs_wen}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("async_rst_wen", {31'b0, bus.ramWEN}, 32'd0);
    chk("async_rst_err", {31'b0, bus.err}, 32'd0);
    step();
    bus.dWEN = 1'b0;
    nRST = 1'b1;
    step();

    // Randomized traffic; requesters hold their request until served or a rare abort.
    for (int c = 0; c < 3000; c++) begin
      if (bus.iREN && !i_done) begin
        if ($urandom_range(0, 15) == 0) bus.iREN = 1'b0;
      end else begin
        bus.iREN  = 1'($urandom_range(0, 1));
        bus.iaddr = $urandom;
      end
      if ((bus.dREN || bus.dWEN) && !d_done) begin
        if ($urandom_range(0, 15) == 0) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; end
      end else begin
        bus.dREN   = 1'($urandom_range(0, 1));
        bus.dWEN   = 1'($urandom_range(0, 1));
        bus.daddr  = $urandom;
        bus.dstore = $urandom;
      end
      r = $urandom_range(0, 39);
      bus.ramstate = (r < 16) ? ACCESS : (r < 28) ? BUSY : (r < 39) ? FREE : ERROR;
      bus.ramload  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
